// File: rtl/hazard_forward_unit_if.sv
// Decode/EX-side bundle for the hazard controller: ID register fields and the
// branch outcome in, forward selects and stall/flush controls out.
interface hazard_forward_unit_if #(
  parameter int unsigned REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic [1:0]        id_result_src;
  logic              ex_branch_taken;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;

  // Pipeline side: drives decode fields, consumes hazard controls.
  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_result_src,
           ex_branch_taken,
    input  fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_result_src,
           ex_branch_taken,
    output fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard controller for the 5-stage core: tracks destination tags of the
// instructions in EX and MEM, registers EX operand forward selects and
// raises load-use stall / branch flush controls.
module hazard_forward_unit #(
  parameter int unsigned REG_AW = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  hazard_forward_unit_if.slave hif
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_PC4 = 2'b11;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic [1:0]        result_src;
  } tag_t;

  // EX keeps the full tag; MEM only needs liveness and rd because any MEM
  // producer forwards the same way. The WB producer is served by the
  // write-through register file, so nothing beyond MEM is tracked.
  tag_t              ex_q;
  logic              mem_live_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic [1:0]        fwd_a_q;
  logic [1:0]        fwd_b_q;

  tag_t       id_tag_c;
  logic       ex_live_c;
  logic       lu_c;
  logic       flush_e_c;
  logic [1:0] fwd_a_d;
  logic [1:0] fwd_b_d;

  // Newest-first forward priority for one source register.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              ex_live,
    input logic [REG_AW-1:0] ex_rd,
    input logic [1:0]        ex_src,
    input logic              mem_live,
    input logic [REG_AW-1:0] mem_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_live && (ex_rd == rs) && (ex_src == SRC_PC4)) begin
      sel = FWD_MEM_PC4;
    end else if (ex_live && (ex_rd == rs) && (ex_src == SRC_ALU)) begin
      sel = FWD_MEM_ALU;
    end else if (mem_live && (mem_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Build the ID tag (illegal result_src folds to ALU), detect hazards and
  // compute the selects the entering instruction will use in EX.
  always_comb begin
    id_tag_c            = '0;
    id_tag_c.valid      = hif.id_valid;
    id_tag_c.rd         = hif.id_rd;
    id_tag_c.reg_write  = hif.id_reg_write;
    id_tag_c.result_src = (hif.id_result_src == 2'b11) ? SRC_ALU : hif.id_result_src;

    ex_live_c = ex_q.valid & ex_q.reg_write & (ex_q.rd != '0);
    lu_c      = hif.id_valid & ex_live_c & (ex_q.result_src == SRC_LOAD) &
                ((hif.id_rs1 == ex_q.rd) | (hif.id_rs2 == ex_q.rd));
    flush_e_c = lu_c | hif.ex_branch_taken;

    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!flush_e_c) begin
      fwd_a_d = fwd_sel(hif.id_rs1, ex_live_c, ex_q.rd, ex_q.result_src, mem_live_q, mem_rd_q);
      fwd_b_d = fwd_sel(hif.id_rs2, ex_live_c, ex_q.rd, ex_q.result_src, mem_live_q, mem_rd_q);
    end
  end

  // Advance the tag pipeline and register the forward selects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      mem_live_q <= 1'b0;
      mem_rd_q   <= '0;
      fwd_a_q    <= FWD_RF;
      fwd_b_q    <= FWD_RF;
    end else begin
      mem_live_q <= ex_live_c;
      mem_rd_q   <= ex_q.rd;
      ex_q       <= flush_e_c ? tag_t'('0) : id_tag_c;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
    end
  end

  assign hif.fwd_a   = fwd_a_q;
  assign hif.fwd_b   = fwd_b_q;
  assign hif.stall_f = lu_c & ~hif.ex_branch_taken;
  assign hif.stall_d = lu_c & ~hif.ex_branch_taken;
  assign hif.flush_d = hif.ex_branch_taken;
  assign hif.flush_e = flush_e_c;

endmodule
